// File: rtl/cereal_rx.sv
// cereal_rx: serial byte receiver for the cereal single-wire link.
// Frame is start(0), 8 data bits LSB first, stop(1); each bit lasts CLKS_PER_BIT sysclk cycles.
// The line is double-flopped, then sampled at the middle of every bit.
//
// Ports:
//   sysclk     system clock, rising edge
//   reset      synchronous active-high reset
//   cereal_in  serial line, idle high, may be asynchronous to sysclk
//   data       last correctly framed byte, held until the next good frame
//   valid      one-cycle strobe, data updated this cycle
//   frame_err  one-cycle strobe, stop bit sampled low
//   busy       high whenever the receiver is not idle
//   rx_count   count of good frames, wraps 255 -> 0
module cereal_rx #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       cereal_in,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy,
   output logic [7:0] rx_count
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHigh
   } state_t;

   state_t        state;
   logic          sync1;
   logic          rx_s;
   logic [CW-1:0] cyc_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= cereal_in;
         rx_s  <= sync1;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state     <= StIdle;
         cyc_cnt   <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         rx_count  <= '0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
         unique case (state)
            StIdle: begin
               if (!rx_s) begin
                  state   <= StStart;
                  cyc_cnt <= '0;
               end
            end
            StStart: begin
               // Re-check the start bit at its middle; a high level here was a glitch.
               if (cyc_cnt == HALF_LAST) begin
                  cyc_cnt <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? StIdle : StData;
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end
            StData: begin
               if (cyc_cnt == BIT_LAST) begin
                  cyc_cnt         <= '0;
                  shift[bit_idx]  <= rx_s;
                  bit_idx         <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= StStop;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end
            StStop: begin
               // Leaving at mid stop bit lets a directly following start bit be seen.
               if (cyc_cnt == BIT_LAST) begin
                  cyc_cnt <= '0;
                  if (rx_s) begin
                     data     <= shift;
                     valid    <= 1'b1;
                     rx_count <= rx_count + 8'd1;
                     state    <= StIdle;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= StWaitHigh;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CW'(1);
               end
            end
            StWaitHigh: begin
               // A held-low (break) line must return high before a new start is accepted.
               if (rx_s) begin
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign busy = (state != StIdle);

endmodule
